// File: rtl/pc_pkg.sv
// Shared types and the next-PC target selection for the fetch PC unit.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_RET    = 2'b11
    } pcsrc_t;

    localparam int unsigned ADDR_MAX = 64;

    typedef logic [ADDR_MAX-1:0] addr_t;

    // Callers zero-extend and truncate; low XLEN bits stay exact mod 2^XLEN.
    function automatic addr_t next_target(
        input pcsrc_t src,
        input addr_t  pc,
        input addr_t  inc,
        input addr_t  imm,
        input addr_t  base,
        input addr_t  ras_top,
        input logic   ras_hit
    );
        addr_t jalr;
        addr_t tgt;
        jalr = (base + imm) & ~addr_t'(1);
        tgt  = pc + inc;
        unique case (src)
            PC_SEQ:    tgt = pc + inc;
            PC_BRANCH: tgt = pc + imm;
            PC_JALR:   tgt = jalr;
            PC_RET:    tgt = ras_hit ? ras_top : jalr;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Return-address stack: circular buffer, saturating count.
module ras_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            rdata,
    output logic [$clog2(DEPTH):0]     cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   top;
    logic            pop_ok;
    logic            swap;

    assign pop_ok = pop && (cnt != '0);
    assign swap   = push && pop_ok;
    assign rdata  = mem[top];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top <= '0;
            cnt <= '0;
        end else if (swap) begin
            top <= top;
        end else if (push) begin
            top <= top + 1'b1;
            if (cnt != CW'(DEPTH))
                cnt <= cnt + 1'b1;
        end else if (pop_ok) begin
            top <= top - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    // Call+return in one cycle rewrites the current top in place.
    always_ff @(posedge clk) begin
        if (push)
            mem[swap ? top : top + 1'b1] <= wdata;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with next-PC mux, fetch stall and return-address stack.
// Optional misaligned-target trap: define PC_MISALIGN_TRAP_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 'h0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] TRAP_VEC  = 'h4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_i,
    input  logic [1:0]                   pcsrc_i,
    input  logic [XLEN-1:0]              imm_i,
    input  logic [XLEN-1:0]              base_i,
    input  logic                         call_i,
    output logic [XLEN-1:0]              pc_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt_o,
    output logic                         misalign_o
);
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] ras_top;
    logic            ras_hit;
    logic            trap;
    logic            push;
    logic            pop;
    logic            mis_q;
    pcsrc_t          src;

    assign src     = pcsrc_t'(pcsrc_i);
    assign seq_pc  = pc_q + XLEN'(INC);
    assign ras_hit = ras_cnt_o != '0;

    assign tgt = XLEN'(next_target(
        src,
        addr_t'(pc_q),
        addr_t'(XLEN'(INC)),
        addr_t'(imm_i),
        addr_t'(base_i),
        addr_t'(ras_top),
        ras_hit
    ));

`ifdef PC_MISALIGN_TRAP_EN
    assign trap = (src != PC_SEQ) && (tgt[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // A trapped redirect leaves the RAS untouched.
    assign push = !stall_i && !trap && call_i && (src != PC_SEQ);
    assign pop  = !stall_i && !trap && (src == PC_RET);

    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (seq_pc),
        .rdata (ras_top),
        .cnt   (ras_cnt_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            mis_q <= 1'b0;
        end else if (stall_i) begin
            mis_q <= 1'b0;
        end else begin
            pc_q  <= trap ? TRAP_VEC : tgt;
            mis_q <= trap;
        end
    end

    assign pc_o       = pc_q;
    assign misalign_o = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed cases then random traffic vs a queue-based model.
module tb_pc_unit;

    localparam int          XLEN  = 32;
    localparam logic [31:0] RVEC  = 32'h100;
    localparam logic [31:0] TVEC  = 32'h4;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b1;
    logic [1:0]  pcsrc_i = 2'b00;
    logic [31:0] imm_i = '0;
    logic [31:0] base_i = '0;
    logic        call_i = 1'b0;
    logic [31:0] pc_o;
    logic [2:0]  ras_cnt_o;
    logic        misalign_o;

    pc_unit #(
        .XLEN      (XLEN),
        .RESET_VEC (RVEC),
        .INC       (4),
        .RAS_DEPTH (DEPTH),
        .TRAP_VEC  (TVEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .pcsrc_i    (pcsrc_i),
        .imm_i      (imm_i),
        .base_i     (base_i),
        .call_i     (call_i),
        .pc_o       (pc_o),
        .ras_cnt_o  (ras_cnt_o),
        .misalign_o (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] pc;
        int          cnt;
        bit          mis;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (pc_o !== e.pc) begin
                failures++;
                $display("FAIL %s pc: got %h want %h", e.tag, pc_o, e.pc);
            end
            checks++;
            if (int'(ras_cnt_o) != e.cnt) begin
                failures++;
                $display("FAIL %s cnt: got %0d want %0d", e.tag, ras_cnt_o, e.cnt);
            end
            checks++;
            if (misalign_o !== e.mis) begin
                failures++;
                $display("FAIL %s misalign: got %0b want %0b", e.tag, misalign_o, e.mis);
            end
        end
    end

    task automatic expect_now(input int due, input string tag, input bit mis);
        exp_t e;
        e.due = due;
        e.pc  = m_pc;
        e.cnt = m_ras.size();
        e.mis = mis;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Reference model: RAS kept as a queue of return addresses, newest at the back.
    task automatic step(input bit st, input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] base, input bit call, input string tag);
        logic [31:0] tgt;
        logic [31:0] jt;
        bit          mis;
        mis = 1'b0;
        @(posedge clk);
        #1;
        stall_i = st;
        pcsrc_i = src;
        imm_i   = imm;
        base_i  = base;
        call_i  = call;
        if (!st) begin
            jt = (base + imm) & 32'hFFFF_FFFE;
            case (src)
                2'd0:    tgt = m_pc + 32'd4;
                2'd1:    tgt = m_pc + imm;
                2'd2:    tgt = jt;
                default: tgt = (m_ras.size() > 0) ? m_ras[$] : jt;
            endcase
`ifdef PC_MISALIGN_TRAP_EN
            if (src != 2'd0 && tgt[1:0] != 2'b00) begin
                mis = 1'b1;
                tgt = TVEC;
            end
`endif
            if (!mis) begin
                if (src == 2'd3 && m_ras.size() > 0) begin
                    if (call)
                        m_ras[m_ras.size()-1] = m_pc + 32'd4;
                    else
                        void'(m_ras.pop_back());
                end else if (call && src != 2'd0) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH)
                        void'(m_ras.pop_front());
                end
            end
            m_pc = tgt;
        end
        expect_now(cyc + 1, tag, mis);
    endtask

    task automatic jump(input logic [31:0] a, input bit call, input string tag);
        step(1'b0, 2'd2, 32'd0, a, call, tag);
    endtask

    initial begin
        int guard;
        m_pc = RVEC;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_now(cyc, "reset", 1'b0);

        step(0, 2'd0, 0, 0, 0, "seq1");
        step(0, 2'd0, 0, 0, 1, "seq2_call_ignored");
        step(0, 2'd0, 0, 0, 0, "seq3");

        jump(32'h200, 0, "to200");
        step(0, 2'd1, 32'hFFFF_FFF8, 0, 0, "branch_neg8");
        jump(32'hFFFF_FFFC, 0, "to_top");
        step(0, 2'd0, 0, 0, 0, "seq_wrap");

        jump(32'h1001, 0, "jalr_mask");
        step(1, 2'd1, 32'h40, 0, 1, "stall_branch");
        step(1, 2'd3, 0, 0, 0, "stall_ret");

        jump(32'h10, 0, "to10");
        jump(32'h20, 1, "call_at10");
        jump(32'h40, 1, "call_at20");
        step(0, 2'd3, 0, 32'h800, 0, "ret1");
        step(0, 2'd3, 0, 32'h800, 0, "ret2");
        step(0, 2'd3, 0, 32'h800, 0, "ret_empty_fallback");

        for (int i = 0; i < 5; i++)
            jump(32'h1000 + 32'(i) * 32'h100, 1, "call_fill");
        for (int i = 0; i < 5; i++)
            step(0, 2'd3, 0, 32'h3000, 0, "ret_drain");

        jump(32'h50, 1, "call_pre_swap");
        step(0, 2'd3, 0, 32'h900, 1, "ret_with_call");
        step(0, 2'd3, 0, 32'h900, 0, "ret_after_swap");
        step(0, 2'd3, 0, 32'h700, 1, "ret_call_empty");

        jump(32'h200, 0, "to200b");
        step(0, 2'd1, 32'h2, 0, 1, "branch_misalign");
        jump(32'h300, 0, "realign");

        for (int i = 0; i < 300; i++) begin
            bit          st;
            logic [1:0]  src;
            logic [31:0] imm;
            logic [31:0] base;
            st   = ($urandom_range(0, 99) < 15);
            src  = 2'($urandom_range(0, 3));
            imm  = 32'($signed($urandom_range(0, 127)) - 64) << 1;
            base = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            step(st, src, imm, base, $urandom_range(0, 1) == 1, "random");
        end

        jump(32'h600, 1, "call_pre_rst");
        jump(32'h700, 1, "call_pre_rst2");
        @(posedge clk);
        @(negedge clk);
        #1;
        pcsrc_i = 2'd2;
        call_i  = 1'b1;
        stall_i = 1'b0;
        rst     = 1'b1;
        m_pc = RVEC;
        m_ras.delete();
        expect_now(cyc + 1, "mid_reset", 1'b0);
        @(posedge clk);
        #1;
        stall_i = 1'b1;
        rst     = 1'b0;
        expect_now(cyc, "post_reset", 1'b0);
        step(0, 2'd0, 0, 0, 0, "seq_after_reset");
        step(0, 2'd3, 0, 32'h44, 0, "ret_after_reset");

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
